// File: rtl/debounce_multi_if.sv
// Button-conditioner bus: raw button inputs towards the conditioner, and the
// cleaned levels, edge pulses and sample-tick strobe back to the consumer.
interface debounce_multi_if #(
    parameter int CHANNELS = 5
) ();
    logic [CHANNELS-1:0] btn_in;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] press;
    logic                tick;

    // Consumer side: drives the raw buttons, observes the conditioned outputs.
    modport master (
        output btn_in,
        input  level, rise, fall, press, tick
    );

    // Conditioner side.
    modport slave (
        input  btn_in,
        output level, rise, fall, press, tick
    );
endinterface

// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: 2-FF synchroniser, tick-based stability
// counter, registered rise/fall pulses and optional hold-to-repeat key events.
module debounce_multi #(
    parameter int                  CHANNELS     = 5,
    parameter bit                  ACTIVE_LOW   = 1'b0,
    parameter int                  TICK_DIV     = 1000,
    parameter int                  STABLE_TICKS = 16,
    parameter logic [CHANNELS-1:0] REPEAT_EN    = '0,
    parameter int                  REPEAT_DELAY = 500,
    parameter int                  REPEAT_RATE  = 100
) (
    input  logic             clk,
    input  logic             reset_n,
    debounce_multi_if.slave  bus
);

    localparam int PW   = $clog2(TICK_DIV + 1);
    localparam int SW   = $clog2(STABLE_TICKS + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [PW-1:0]       PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]       STAB_LAST  = SW'(STABLE_TICKS - 1);
    localparam logic [RW-1:0]       DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]       RATE_LAST  = RW'(REPEAT_RATE - 1);
    localparam logic [CHANNELS-1:0] POLARITY   = {CHANNELS{ACTIVE_LOW}};

    logic [PW-1:0]       pre_cnt;
    logic [PW-1:0]       pre_next;
    logic                tick_q;
    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;
    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] fall_q;
    logic [CHANNELS-1:0] press_q;
    logic [SW-1:0]       stab_cnt [CHANNELS];
    logic [RW-1:0]       rep_cnt  [CHANNELS];
    logic [CHANNELS-1:0] rep_phase;   // 0: waiting for first repeat, 1: steady rate
    logic [CHANNELS-1:0] flip;
    logic [CHANNELS-1:0] rep_hit;

    // Next prescaler count, wrapping at TICK_DIV-1.
    always_comb begin
        pre_next = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
    end

    // Prescaler; tick is registered so it is high exactly while the count sits at TICK_DIV-1.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block ordering.
        if (!reset_n) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
        end else begin
            pre_cnt <= pre_next;
            tick_q  <= (pre_next == PRE_LAST);
        end
    end

    // Two-flop synchroniser with polarity fix in front of it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.btn_in ^ POLARITY;
            s2 <= s1;
        end
    end

    // Per-channel decisions: level flip on the last qualifying tick, repeat hit while held.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        flip    = '0;
        rep_hit = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            flip[i]    = tick_q && (s2[i] != level_q[i]) && (stab_cnt[i] == STAB_LAST);
            rep_hit[i] = REPEAT_EN[i] && level_q[i] && !flip[i] && tick_q &&
                         (rep_cnt[i] == (rep_phase[i] ? RATE_LAST : DELAY_LAST));
        end
    end

    // Stability counters, debounced level and registered edge/press pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            press_q <= '0;
            // NOTE: the counter arrays are small per-channel registers, not RAM,
            // so clearing every entry on reset is intended.
            for (int i = 0; i < CHANNELS; i++) begin
                stab_cnt[i] <= '0;
            end
        end else begin
            level_q <= level_q ^ flip;
            rise_q  <= flip & s2;
            fall_q  <= flip & ~s2;
            press_q <= (flip & s2) | rep_hit;
            for (int i = 0; i < CHANNELS; i++) begin
                if (s2[i] == level_q[i]) begin
                    stab_cnt[i] <= '0;                 // any agreeing cycle kills a glitch
                end else if (tick_q) begin
                    stab_cnt[i] <= flip[i] ? '0 : stab_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Auto-repeat timers: cleared while released, on rise and on fall; reload after each pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rep_phase <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!REPEAT_EN[i] || !level_q[i] || flip[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (tick_q) begin
                    if (rep_hit[i]) begin
                        rep_cnt[i]   <= '0;
                        rep_phase[i] <= 1'b1;
                    end else begin
                        rep_cnt[i] <= rep_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.level = level_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;
    assign bus.press = press_q;
    assign bus.tick  = tick_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: two instances (TICK_DIV=1 and TICK_DIV=4) share the
// button stimulus; a cycle-level behavioural model checks every output on every
// cycle, and directed scenarios pin the model with hand-computed expectations.
module tb_debounce_multi;

    localparam int         CH   = 5;
    localparam bit         AL   = 1'b0;
    localparam int         ST   = 4;
    localparam logic [4:0] REN  = 5'b00001;
    localparam int         DLY  = 8;
    localparam int         RATE = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [CH-1:0] btn;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    debounce_multi_if #(.CHANNELS(CH)) bus_a ();
    debounce_multi_if #(.CHANNELS(CH)) bus_b ();

    assign bus_a.btn_in = btn;
    assign bus_b.btn_in = btn;

    debounce_multi #(
        .CHANNELS(CH), .ACTIVE_LOW(AL), .TICK_DIV(1), .STABLE_TICKS(ST),
        .REPEAT_EN(REN), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );

    debounce_multi #(
        .CHANNELS(CH), .ACTIVE_LOW(AL), .TICK_DIV(4), .STABLE_TICKS(ST),
        .REPEAT_EN(REN), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. Index 0 mirrors dut_a, index 1 mirrors dut_b.
    // Level flips once the synchronised input has disagreed with it for
    // ST sampled ticks without a single agreeing cycle in between; a held
    // repeat key fires when the ticks held since rise equal DLY, DLY+RATE, ...
    // ------------------------------------------------------------------
    logic [CH-1:0] m_s1 [2];
    logic [CH-1:0] m_s2 [2];
    logic [CH-1:0] m_lvl [2];
    logic [CH-1:0] m_rise [2];
    logic [CH-1:0] m_fall [2];
    logic [CH-1:0] m_press [2];
    logic          m_tick [2];
    int            m_run  [2][CH];   // ticks in the current disagreeing run
    int            m_held [2][CH];   // ticks held since the last rise
    int            m_cyc  [2];       // cycles since the last reset edge
    bit            model_valid = 1'b0;

    task automatic model_step(input int k, input int td, input logic r, input logic [CH-1:0] b);
        logic          t_now;
        logic [CH-1:0] new_lvl;
        if (!r) begin
            m_s1[k] = '0; m_s2[k] = '0; m_lvl[k] = '0;
            m_rise[k] = '0; m_fall[k] = '0; m_press[k] = '0;
            m_tick[k] = 1'b0;
            m_cyc[k] = 0;
            for (int i = 0; i < CH; i++) begin
                m_run[k][i] = 0;
                m_held[k][i] = 0;
            end
        end else begin
            t_now = m_tick[k];
            new_lvl = m_lvl[k];
            m_press[k] = '0;
            for (int i = 0; i < CH; i++) begin
                if (m_s2[k][i] == m_lvl[k][i]) begin
                    m_run[k][i] = 0;
                end else if (t_now) begin
                    m_run[k][i]++;
                    if (m_run[k][i] == ST) begin
                        new_lvl[i] = m_s2[k][i];
                        m_run[k][i] = 0;
                    end
                end
                if (REN[i] && m_lvl[k][i] && new_lvl[i] && t_now) begin
                    m_held[k][i]++;
                    if (m_held[k][i] == DLY ||
                        (m_held[k][i] > DLY && (m_held[k][i] - DLY) % RATE == 0))
                        m_press[k][i] = 1'b1;
                end
            end
            m_rise[k] = new_lvl & ~m_lvl[k];
            m_fall[k] = ~new_lvl & m_lvl[k];
            for (int i = 0; i < CH; i++)
                if (m_rise[k][i]) m_held[k][i] = 0;
            m_press[k] = m_press[k] | m_rise[k];
            m_lvl[k] = new_lvl;
            m_s2[k] = m_s1[k];
            m_s1[k] = b ^ {CH{AL}};
            m_cyc[k]++;
            m_tick[k] = (m_cyc[k] % td == td - 1);
        end
    endtask

    // Advance the model on every active edge from the pre-edge inputs.
    always @(posedge clk) begin
        model_step(0, 1, reset_n, btn);
        model_step(1, 4, reset_n, btn);
        model_valid = 1'b1;
    end

    task automatic compare_inst(input int k, input string tag,
                                input logic [CH-1:0] lv, input logic [CH-1:0] ri,
                                input logic [CH-1:0] fa, input logic [CH-1:0] pr,
                                input logic tk);
        check({tag, ".level"}, 32'(lv), 32'(m_lvl[k]));
        check({tag, ".rise"},  32'(ri), 32'(m_rise[k]));
        check({tag, ".fall"},  32'(fa), 32'(m_fall[k]));
        check({tag, ".press"}, 32'(pr), 32'(m_press[k]));
        check({tag, ".tick"},  32'(tk), 32'(m_tick[k]));
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            compare_inst(0, "a", bus_a.level, bus_a.rise, bus_a.fall, bus_a.press, bus_a.tick);
            compare_inst(1, "b", bus_b.level, bus_b.rise, bus_b.fall, bus_b.press, bus_b.tick);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Hard stop in case a wait ever fails to terminate.
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    // Directed scenarios followed by randomized stimulus.
    initial begin
        int     seen, rise_cnt, press_cnt, fall_at, got, late, tick_cnt, gap_bad, prev, at;
        bit     fall_seen;
        int     offs[$];
        int     exp4[8] = '{8, 11, 14, 17, 20, 23, 26, 29};
        int     rem[CH];
        logic [CH-1:0] nb;

        // 1. Reset with all buttons held.
        reset_n = 1'b0;
        btn = '1;
        repeat (3) step();
        check("t1 level in reset", 32'(bus_a.level), 32'h0);
        check("t1 rise in reset",  32'(bus_a.rise),  32'h0);
        check("t1 press in reset", 32'(bus_a.press), 32'h0);
        check("t1 tick in reset",  32'(bus_a.tick),  32'h0);
        reset_n = 1'b1;
        repeat (5) step();
        check("t1 level before edge 6", 32'(bus_a.level), 32'h00);
        step();
        check("t1 level at edge 6", 32'(bus_a.level), 32'h1F);
        check("t1 rise at edge 6",  32'(bus_a.rise),  32'h1F);
        check("t1 press at edge 6", 32'(bus_a.press), 32'h1F);
        step();
        check("t1 rise one cycle", 32'(bus_a.rise), 32'h00);
        btn = '0;
        repeat (40) step();
        check("t1 all released", 32'(bus_a.level), 32'h00);

        // 2. Short glitches on ch1 are rejected, and one agreeing cycle restarts the count.
        seen = 0;
        btn = 5'b00010;
        repeat (3) step();
        btn = 5'b00000;
        step();
        btn = 5'b00010;
        repeat (3) step();
        btn = 5'b00000;
        repeat (12) begin
            step();
            if (bus_a.level[1] || bus_a.rise[1] || bus_a.press[1]) seen++;
        end
        check("t2 glitch rejected", 32'(seen), 32'h0);

        // 3. ch1 held 20 cycles then released.
        rise_cnt = 0; press_cnt = 0; fall_at = -1;
        btn = 5'b00010;
        repeat (20) begin
            step();
            rise_cnt  += int'(bus_a.rise[1]);
            press_cnt += int'(bus_a.press[1]);
        end
        btn = 5'b00000;
        for (int j = 1; j <= 15; j++) begin
            step();
            press_cnt += int'(bus_a.press[1]);
            if (bus_a.fall[1] && fall_at < 0) fall_at = j;
        end
        check("t3 rise count",  32'(rise_cnt),  32'd1);
        check("t3 press count", 32'(press_cnt), 32'd1);
        check("t3 fall latency", 32'(fall_at), 32'(ST + 2));
        repeat (30) step();

        // 5. TICK_DIV=4 instance: tick every 4th cycle, slower flip.
        tick_cnt = 0; gap_bad = 0; prev = -1;
        for (int j = 0; j < 16; j++) begin
            step();
            if (bus_b.tick) begin
                tick_cnt++;
                if (prev >= 0 && j - prev != 4) gap_bad++;
                prev = j;
            end
        end
        check("t5 tick count", 32'(tick_cnt), 32'd4);
        check("t5 tick spacing", 32'(gap_bad), 32'd0);
        btn = 5'b00010;
        repeat (14) step();
        check("t5 level held off", 32'(bus_b.level[1]), 32'h0);
        repeat (4) step();
        check("t5 level flipped", 32'(bus_b.level[1]), 32'h1);
        btn = 5'b00000;
        repeat (30) step();

        // 4. ch0 auto-repeat.
        btn = 5'b00001;
        got = 0;
        for (int j = 0; j < 20 && got == 0; j++) begin
            step();
            if (bus_a.rise[0]) got = 1;
        end
        check("t4 rise seen", 32'(got), 32'd1);
        for (int j = 1; j <= 30; j++) begin
            step();
            if (bus_a.press[0]) offs.push_back(j);
        end
        check("t4 repeat count", 32'(offs.size()), 32'd8);
        for (int j = 0; j < 8 && j < offs.size(); j++)
            check("t4 repeat offset", 32'(offs[j]), 32'(exp4[j]));
        btn = 5'b00000;
        fall_seen = 1'b0; late = 0;
        for (int j = 0; j < 20; j++) begin
            step();
            if (bus_a.fall[0]) fall_seen = 1'b1;
            if (fall_seen && bus_a.press[0]) late++;
        end
        check("t4 fall seen", 32'(fall_seen), 32'd1);
        check("t4 no press after fall", 32'(late), 32'd0);
        repeat (20) step();

        // 6. Reset mid-repeat on ch0.
        btn = 5'b00001;
        got = 0;
        for (int j = 0; j < 20 && got == 0; j++) begin
            step();
            if (bus_a.rise[0]) got = 1;
        end
        check("t6 rise seen", 32'(got), 32'd1);
        repeat (10) step();
        reset_n = 1'b0;
        step();
        check("t6 level cleared", 32'(bus_a.level), 32'h0);
        check("t6 press cleared", 32'(bus_a.press), 32'h0);
        check("t6 rise cleared",  32'(bus_a.rise),  32'h0);
        check("t6 fall cleared",  32'(bus_a.fall),  32'h0);
        check("t6 b level cleared", 32'(bus_b.level), 32'h0);
        reset_n = 1'b1;
        at = -1;
        for (int j = 1; j <= 20 && at < 0; j++) begin
            step();
            if (bus_a.rise[0]) at = j;
        end
        check("t6 fresh rise edge", 32'(at), 32'd6);
        at = -1;
        for (int j = 1; j <= 12 && at < 0; j++) begin
            step();
            if (bus_a.press[0]) at = j;
        end
        check("t6 first repeat restarted", 32'(at), 32'(DLY));
        btn = 5'b00000;
        repeat (30) step();

        // Randomized segments: short bursts and long holds per channel, rare resets.
        for (int i = 0; i < CH; i++) rem[i] = 0;
        nb = '0;
        repeat (3000) begin
            for (int i = 0; i < CH; i++) begin
                if (rem[i] == 0) begin
                    nb[i] = 1'($urandom_range(0, 1));
                    rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 50))
                                                         : int'($urandom_range(1, 8));
                end
                rem[i]--;
            end
            btn = nb;
            reset_n = ($urandom_range(0, 399) != 0);
            step();
        end
        reset_n = 1'b1;
        btn = '0;
        repeat (40) step();
        check("final released level a", 32'(bus_a.level), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
